// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared sizing function and fade-difference helper for pwm_bank.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  // Widest duty/counter resolution supported by the bank.
  localparam int c_MAX_W = 16;

  // Width of a channel index; a single-channel bank still gets a 1-bit index.
  function automatic int ch_idx_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  // Signed target-minus-active difference; one extra bit means it never wraps.
  function automatic logic signed [c_MAX_W:0] fade_diff(
    input logic [c_MAX_W-1:0] target,
    input logic [c_MAX_W-1:0] active
  );
    return $signed({1'b0, target}) - $signed({1'b0, active});
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_channel
// Purpose  : One PWM channel: target/step/active duty registers, per-period
//            linear fade toward the target and the registered compare output.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         wrap,
  input  logic         wr_en,
  input  logic [W-1:0] wr_duty,
  input  logic [W-1:0] wr_step,
  input  logic [W-1:0] cnt,
  output logic         pwm_out
);

  logic [W-1:0]        r_target;
  logic [W-1:0]        r_step;
  logic [W-1:0]        r_active;
  logic signed [W:0]   w_diff;
  logic [W:0]          w_mag;
  logic [W-1:0]        w_next;

  // Next active duty: snap to target when close enough (or step 0), else move by step.
  always_comb begin
    w_diff = (W+1)'(fade_diff(c_MAX_W'(r_target), c_MAX_W'(r_active)));
    w_mag  = w_diff[W] ? (~w_diff + 1'b1) : w_diff;
    w_next = r_target;
    if ((r_step != '0) && (w_mag > {1'b0, r_step})) begin
      if (w_diff[W]) begin
        w_next = r_active - r_step;
      end else begin
        w_next = r_active + r_step;
      end
    end
  end

  // Active only changes on wrap, so a write can never glitch the current period;
  // on a write/wrap collision the wrap sees the pre-write target/step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_target <= '0;
      r_step   <= '0;
      r_active <= '0;
      pwm_out  <= 1'b0;
    end else begin
      if (wrap) begin
        r_active <= w_next;
      end
      if (wr_en) begin
        r_target <= wr_duty;
        r_step   <= wr_step;
      end
      pwm_out <= en && (cnt < r_active);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_bank.sv
`default_nettype none
// ============================================================================
// Module   : pwm_bank
// Purpose  : Multi-channel PWM generator with prescaler, shared period counter,
//            valid/ready duty writes and per-channel fading.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int CH       = 3,
  parameter int W        = 8,
  parameter int PRESCALE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ch_idx_w(CH)-1:0] wr_ch,
  input  logic [W-1:0]            wr_duty,
  input  logic [W-1:0]            wr_step,
  output logic                    period_start,
  output logic [CH-1:0]           pwm_out
);

  localparam int                c_CHW     = ch_idx_w(CH);
  localparam int                c_PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PW-1:0]   c_PRE_MAX = c_PW'(PRESCALE - 1);

  logic [c_PW-1:0] r_pre;
  logic [W-1:0]    r_cnt;
  logic            r_en_d;
  logic            w_tick;
  logic            w_wrap;
  logic            w_fire;

  assign wr_ready = rst;
  assign w_fire   = wr_valid && wr_ready;
  assign w_tick   = en && (r_pre == c_PRE_MAX);
  assign w_wrap   = w_tick && (r_cnt == '1);

  // Prescaler and period counter; disable parks both at zero so a re-enable
  // starts a fresh period. period_start marks each new period.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pre        <= '0;
      r_cnt        <= '0;
      r_en_d       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      if (!en) begin
        r_pre <= '0;
        r_cnt <= '0;
      end else if (w_tick) begin
        r_pre <= '0;
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      r_en_d       <= en;
      period_start <= w_wrap || (en && !r_en_d);
    end
  end

  // One channel per output; indices at or above CH match no channel and are dropped.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic w_we;
    assign w_we = w_fire && (wr_ch == c_CHW'(i));

    pwm_channel #(
      .W(W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .wrap    (w_wrap),
      .wr_en   (w_we),
      .wr_duty (wr_duty),
      .wr_step (wr_step),
      .cnt     (r_cnt),
      .pwm_out (pwm_out[i])
    );
  end

endmodule
`default_nettype wire

// File: doc/pwm_bank.md
# pwm_bank

Parametrised multi-channel PWM generator. It supersedes the fixed 3-channel, 8-bit RGB PWM controller. It adds configurable channel count, resolution and clock prescale, double-buffered duty registers written over a valid/ready port, and per-channel linear fading toward a target duty. It sits between the register/command front end and the LED/actuator pins.

## Interface
Parameters:
- `CH`, 3, number of PWM channels (1..16)
- `W`, 8, duty/counter resolution in bits (4..16); period = 2^W counts
- `PRESCALE`, 1, clocks per counter increment (1..65536)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `en`  in  1  global enable; 0 freezes the period counter at 0 and forces outputs low
- `wr_valid`  in  1  write request
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`
- `wr_ch`  in  max(1,$clog2(CH))  target channel; values >= CH are accepted and discarded
- `wr_duty`  in  W  target duty (high counts per period)
- `wr_step`  in  W  fade step per period; 0 = jump directly to target
- `period_start`  out  1  one-cycle pulse at the start of each period
- `pwm_out`  out  CH  registered PWM outputs, active-high

## Operation
- Per channel there are three registers: `target` (W bits), `step` (W bits) and `active` (W bits). The compare uses `active` only.
- Prescaler `pre` counts 0..PRESCALE-1 while `en=1`. `tick` = (`pre` == PRESCALE-1). With PRESCALE=1, `tick` is 1 on every enabled cycle.
- Counter `cnt` (W bits) increments on `tick` and wraps from 2^W-1 to 0. `wrap` = `tick && cnt==2^W-1`.
- On `wrap`, each channel updates `active` from its registered `target`/`step` values:
  - If `step`==0 or |target-active| <= step: `active` <= `target`.
  - Else `active` moves toward `target` by `step`. Compute the difference in W+1 bits; no overflow or underflow is permitted.
- Compare: `pwm_out[i]` <= `en && (cnt < active[i])`.
  - Duty 0 gives always low.
  - Duty 2^W-1 gives high for 2^W-1 of 2^W counts. There is no 100% state.
- Writes:
  - `wr_ready` = 1 whenever `rst`=1. It is 0 during reset.
  - An accepted write loads `target[wr_ch]` and `step[wr_ch]` only. The new value reaches `active` no earlier than the next `wrap`, so there is never a mid-period glitch.
- Simultaneous write and `wrap` to the same channel: the `wrap` update uses the pre-write `target`/`step`, and the write lands in `target`/`step`. The new value reaches `active` at the following `wrap`.
- Back-to-back writes to the same channel: the last write before a `wrap` wins.
- `en` deassert: next edge clears `pre` and `cnt` to 0 and drives `pwm_out` to 0. `active` is held and writes are still accepted. When `en` reasserts, the period restarts from `cnt`=0.
- Reset (any cycle, including mid-period or mid-fade): `pre`, `cnt`, `target`, `step`, `active`, `pwm_out` and `period_start` all go to 0 on the next edge.

## Timing
- `pwm_out` has 1-cycle latency: the output in cycle t+1 reflects `cnt`/`active` in cycle t.
- `period_start` is registered and asserted for exactly one cycle:
  - the cycle after each `wrap`, i.e. the first cycle in which `cnt`=0 and the new `active` values are visible;
  - also the first cycle after `en` rises from 0 (counter already 0).
- Period length = PRESCALE * 2^W clocks. High time = PRESCALE * active clocks.
- Fade from `a` to `t` with step `s` > 0 completes in ceil(|t-a|/s) periods.
- Write-to-output latency: from accept to the first affected high cycle, at most one full period plus 2 clocks.

## Structure
- Shared package `pwm_pkg`:
  - channel-index width function;
  - the W+1-bit signed-difference helper used by the fade step.
- Sub-module `pwm_channel` (instantiated CH times) holds `target`, `step` and `active`, the fade update and the compare/output register. Its inputs are `wrap`, the write strobe, `cnt` and `en`.
- Top level holds the prescaler, period counter, write decode and `period_start` register.

## Test plan
- **Reset**: hold `rst`=0 for 3 cycles mid-fade with outputs high. Expect `pwm_out`=0, `period_start`=0 and `wr_ready`=0 during reset. After release, the first period starts at `cnt`=0.
- **Immediate duty** (CH=3, W=8, PRESCALE=1): write ch0 duty=64 step=0 mid-period.
  - The current period is unchanged.
  - Starting the period after the next `wrap`, ch0 is high for exactly 64 of 256 clocks.
  - ch1 and ch2 stay low.
- **Extremes**: duty 0 never goes high. Duty 255 is high 255 of 256 clocks, low only at `cnt`=255.
- **Fade**:
  - From active 0, write target 200 step 50: successive periods show active 50, 100, 150, 200, then stable.
  - Then write target 10 step 50: 150, 100, 50, 10.
  - Check there is no wrap-around past the target.
- **Prescale** (PRESCALE=4): `period_start` pulses every 1024 clocks. Duty 128 gives 512 high clocks per period.
- **Collisions**:
  - A write to ch1 in the exact `wrap` cycle takes effect one period later.
  - `en` dropped mid-period gives `pwm_out`=0 on the next clock. On reassert, `period_start` pulses and the count restarts from 0.
  - A write with `wr_ch`=3 (CH=3) changes nothing.
